// File: rtl/mcpu_pkg.sv
// Constants and loader state encoding shared by MCPU, the program loader and their benches.
package mcpu_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int BYTE_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;

  // A count byte of zero means "fill the whole RAM".
  localparam int FULL_COUNT = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/mcpu_prog_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
// Stream handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
// in_data is ignored otherwise and the source may drop in_valid between any two bytes.
interface mcpu_prog_loader_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mcpu_prog_loader.sv
// Boot loader: receives count, words (MSB byte first) and an XOR checksum, writes MCPU RAM
// from address 0 and releases cpu_reset only after a load whose checksum matches.
module mcpu_prog_loader #(
  parameter int WORD_SIZE  = mcpu_pkg::WORD_SIZE,
  parameter int BYTE_WIDTH = mcpu_pkg::BYTE_WIDTH,
  parameter int ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  mcpu_prog_loader_if.slave      bus,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output mcpu_pkg::loader_state_t state_dbg
);
  import mcpu_pkg::*;

  loader_state_t         state;
  logic [ADDR_WIDTH:0]   n_words;
  logic [ADDR_WIDTH:0]   wcnt;
  logic [ADDR_WIDTH:0]   wcnt_next;
  logic [ADDR_WIDTH:0]   count_words;
  logic [BYTE_WIDTH-1:0] hi_byte;
  logic [BYTE_WIDTH-1:0] csum;
  logic                  take;

  assign take      = bus.in_valid && bus.in_ready;
  assign wcnt_next = wcnt + 1'b1;
  assign state_dbg = state;

  // One extra counter bit lets 2**ADDR_WIDTH words be counted without wrapping.
  always_comb begin
    count_words = (ADDR_WIDTH+1)'(bus.in_data);
    if (bus.in_data == '0) count_words = {1'b1, {ADDR_WIDTH{1'b0}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_reset     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      n_words       <= '0;
      wcnt          <= '0;
      hi_byte       <= '0;
      csum          <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_COUNT;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            bus.mem_addr <= '0;
            csum         <= '0;
            wcnt         <= '0;
          end
        end
        S_COUNT: begin
          if (take) begin
            n_words <= count_words;
            csum    <= csum ^ bus.in_data;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (take) begin
            hi_byte <= bus.in_data;
            csum    <= csum ^ bus.in_data;
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (take) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wcnt[ADDR_WIDTH-1:0];
            bus.mem_wdata <= WORD_SIZE'({hi_byte, bus.in_data});
            wcnt          <= wcnt_next;
            csum          <= csum ^ bus.in_data;
            state         <= (wcnt_next == n_words) ? S_CHECK : S_HI;
          end
        end
        S_CHECK: begin
          if (take) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mcpu_prog_loader.md
Name: mcpu_prog_loader

Overview:
- Boot-time program loader sitting directly upstream of MCPU.
- Accepts a byte stream (count, instruction words, checksum) over a valid/ready handshake.
- Writes each assembled instruction word into MCPU RAM from address 0 upward.
- Holds the CPU in reset until a load completes with a correct checksum, replacing testbench-side memory preloading.

Parameters:
- WORD_SIZE, 16, instruction width; must equal 2*BYTE_WIDTH.
- BYTE_WIDTH, 8, stream byte width.
- ADDR_WIDTH, 8, RAM address width; max program length is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: begin a new load.
- in_data  input  BYTE_WIDTH  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  RAM write strobe.
- mem_addr  output  ADDR_WIDTH  RAM write address.
- mem_wdata  output  WORD_SIZE  RAM write data.
- cpu_reset  output  1  active-high reset to MCPU.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- err  output  1  last load failed its checksum.

Behaviour:
- Reset values (applied asynchronously on reset=0): state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0. Checksum and word counter cleared.
- Handshake: a byte is consumed on a rising edge with in_valid && in_ready. in_ready=1 only in COUNT, HI, LO and CHECK. in_data is don't-care when not consumed.
- Stream format: count byte N (0 means 2**ADDR_WIDTH), then N words sent MSB byte first, then one checksum byte.
- Checksum: XOR of the count byte and all data bytes.
- All outputs are registered.

States:
- IDLE: start → COUNT. Entry clears done, err, mem_addr and checksum, and sets cpu_reset=1, busy=1.
- COUNT: byte consumed → latch N, → HI.
- HI: byte consumed → latch the high byte, → LO.
- LO: byte consumed → next cycle mem_we=1 for exactly one cycle, with mem_addr = current address and mem_wdata = {hi, lo}. The address increments after the write.
  - → CHECK if N words have now been written.
  - → HI otherwise.
- CHECK: byte consumed → compare with the running XOR.
  - Match → DONE: next cycle cpu_reset=0, done=1, busy=0.
  - Mismatch → ERROR: err=1, busy=0, cpu_reset stays 1.
- DONE / ERROR: start → COUNT, applying the same entry actions as IDLE → COUNT.

Boundary conditions:
- start in COUNT, HI, LO or CHECK is ignored.
- start and in_valid in the same IDLE cycle: the byte is not consumed (in_ready=0 in IDLE).
- N=0: 256 words are written; the last write is to address 0xFF. The address counter is ADDR_WIDTH+1 bits wide internally, so the address never wraps within a load.
- Gaps and backpressure: in_valid may drop between any two bytes; the state holds.
- Reset mid-load: outputs go to reset values immediately. Words already written stay in RAM. The next start reloads from address 0.
- Load latency: the last write occurs 1 cycle after the last LO byte. cpu_reset releases 1 cycle after the checksum byte.

Decomposition:
- Shared package (mcpu_pkg): WORD_SIZE, ADDR_WIDTH, the loader state encoding (IDLE, COUNT, HI, LO, CHECK, DONE, ERROR) and the count-0-means-full-RAM constant. MCPU and benches import WORD_SIZE from the same package.
- Single module, no sub-module. The byte-to-word assembler is too small to split out.

Test Plan:
- Good load: start; bytes 02,10,01,22,64,55 → mem_we pulses at addr 0 with data 0x1001, then at addr 1 with 0x2264. One cycle after byte 55: done=1, cpu_reset=0, busy=0.
- Bad checksum: same stream with last byte 54 → err=1, cpu_reset=1, no write after addr 1. A new start plus the good stream → done=1, err=0.
- Backpressure and gaps: the good stream with in_valid toggling 1-0-0-1 → identical writes and result; in_ready=0 in IDLE and DONE, so no extra bytes are consumed.
- Full RAM: count 00 followed by 256 words → the last mem_we is at addr 0xFF with no wrap to 0. A correct checksum gives done=1.
- Reset mid-load: assert reset=0 after bytes 02,10,01 → mem_we=0, cpu_reset=1 and busy=0 in the same cycle. Release reset, start, send the good stream → writes at addr 0 and 1 as in the good-load scenario.
- start pulses during HI/LO → ignored; the stream completes normally with done=1.
